// File: rtl/dfm_pkg.sv
// Shared definitions for the digital frequency meter datapath: widths,
// the measurement write address, grant encoding and a saturating add.
package dfm_pkg;

  localparam int A_AW  = 2;
  localparam int A_DW  = 8;
  localparam int B_DW  = 96;
  localparam int CNT_W = 8;

  localparam logic [A_AW:0] B_ADDR = 3'b100;

  typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} gnt_t;

  // Adds a small increment to the drop counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {{(CNT_W - 1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/wr_slot.sv
// One-entry holding register for a write requester. A load always captures
// the newest value; ovf_o flags that a still-pending entry was replaced.
module wr_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         consume_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         ovf_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next state: a load wins over a consume, so a same-cycle request and
  // grant leaves the new entry pending while the old one is written.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_o   = 1'b0;
    if (consume_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ovf_o   = valid_q && !consume_i;
    end
  end

  // Slot state register; a reset discards any pending entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port between the SPI
// command path (A) and the measurement path (B). Writes stall while a
// regfile read is active; overwritten slot entries are flagged and counted.
module reg_wr_arbiter #(
  parameter int                    A_AW   = dfm_pkg::A_AW,
  parameter int                    A_DW   = dfm_pkg::A_DW,
  parameter int                    B_DW   = dfm_pkg::B_DW,
  parameter logic [A_AW:0]         B_ADDR = dfm_pkg::B_ADDR
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              a_req_i,
  input  logic [A_AW-1:0]   a_addr_i,
  input  logic [A_DW-1:0]   a_data_i,
  input  logic              b_req_i,
  input  logic [B_DW-1:0]   b_data_i,
  input  logic              rd_en_i,
  input  logic              clr_i,
  output logic              reg_wr_en_o,
  output logic [A_AW:0]     reg_wr_addr_o,
  output logic [B_DW-1:0]   reg_wr_data_o,
  output logic              ovf_a_o,
  output logic              ovf_b_o,
  output logic [7:0]        drop_cnt_o
);

  import dfm_pkg::*;

  localparam int AW_SLOT = A_AW + A_DW;

  logic               a_valid, b_valid;
  logic [AW_SLOT-1:0] a_slot;
  logic [B_DW-1:0]    b_slot;
  logic               a_ovf, b_ovf;

  gnt_t       gnt;
  gnt_t       last_q, last_d;
  logic       ovf_a_q, ovf_a_d;
  logic       ovf_b_q, ovf_b_d;
  logic [7:0] cnt_q, cnt_d;

  wr_slot #(.W(AW_SLOT)) u_slot_a (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load_i    (a_req_i),
    .data_i    ({a_addr_i, a_data_i}),
    .consume_i (gnt == GNT_A),
    .valid_o   (a_valid),
    .data_o    (a_slot),
    .ovf_o     (a_ovf)
  );

  wr_slot #(.W(B_DW)) u_slot_b (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load_i    (b_req_i),
    .data_i    (b_data_i),
    .consume_i (gnt == GNT_B),
    .valid_o   (b_valid),
    .data_o    (b_slot),
    .ovf_o     (b_ovf)
  );

  // Grant: reads block everything; on a tie the slot not served last wins.
  always_comb begin
    gnt = GNT_NONE;
    if (!rd_en_i) begin
      if (a_valid && b_valid) begin
        gnt = (last_q == GNT_A) ? GNT_B : GNT_A;
      end else if (a_valid) begin
        gnt = GNT_A;
      end else if (b_valid) begin
        gnt = GNT_B;
      end
    end
  end

  // Write port mux; idle cycles drive zeros rather than stale slot data.
  always_comb begin
    reg_wr_en_o   = 1'b0;
    reg_wr_addr_o = '0;
    reg_wr_data_o = '0;
    unique case (gnt)
      GNT_A: begin
        reg_wr_en_o   = 1'b1;
        reg_wr_addr_o = {1'b0, a_slot[AW_SLOT-1:A_DW]};
        reg_wr_data_o = {{(B_DW - A_DW){1'b0}}, a_slot[A_DW-1:0]};
      end
      GNT_B: begin
        reg_wr_en_o   = 1'b1;
        reg_wr_addr_o = B_ADDR;
        reg_wr_data_o = b_slot;
      end
      default: ;
    endcase
  end

  // Next state for round-robin pointer, sticky flags and drop counter;
  // a clear overrides any overwrite seen in the same cycle.
  always_comb begin
    last_d  = (gnt != GNT_NONE) ? gnt : last_q;
    ovf_a_d = ovf_a_q | a_ovf;
    ovf_b_d = ovf_b_q | b_ovf;
    cnt_d   = sat_add(cnt_q, {1'b0, a_ovf} + {1'b0, b_ovf});
    if (clr_i) begin
      ovf_a_d = 1'b0;
      ovf_b_d = 1'b0;
      cnt_d   = '0;
    end
  end

  // Status and pointer registers; B counts as last served so A wins the
  // first tie after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q  <= GNT_B;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      last_q  <= last_d;
      ovf_a_q <= ovf_a_d;
      ovf_b_q <= ovf_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ovf_a_o    = ovf_a_q;
  assign ovf_b_o    = ovf_b_q;
  assign drop_cnt_o = cnt_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: a directed table of cycles with hand-derived
// expectations, then random traffic, a long stall and a mid-stall reset
// checked against a queue-based reference model.
module tb_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req;
  logic [1:0]  a_addr;
  logic [7:0]  a_data;
  logic        b_req;
  logic [95:0] b_data;
  logic        rd_en;
  logic        clr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [95:0] wr_data;
  logic        ovf_a;
  logic        ovf_b;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  reg_wr_arbiter dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .a_req_i       (a_req),
    .a_addr_i      (a_addr),
    .a_data_i      (a_data),
    .b_req_i       (b_req),
    .b_data_i      (b_data),
    .rd_en_i       (rd_en),
    .clr_i         (clr),
    .reg_wr_en_o   (wr_en),
    .reg_wr_addr_o (wr_addr),
    .reg_wr_data_o (wr_data),
    .ovf_a_o       (ovf_a),
    .ovf_b_o       (ovf_b),
    .drop_cnt_o    (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ar;
    logic [1:0]  aa;
    logic [7:0]  ad;
    logic        br;
    logic [95:0] bd;
    logic        rd;
    logic        cl;
    logic        en;
    logic [2:0]  addr;
    logic [95:0] data;
    logic        oa;
    logic        ob;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic ar, input logic [1:0] aa, input logic [7:0] ad,
                              input logic br, input logic [95:0] bd, input logic rd, input logic cl,
                              input logic en, input logic [2:0] addr, input logic [95:0] data,
                              input logic oa, input logic ob, input logic [7:0] cnt);
    vec_t v;
    v.ar = ar; v.aa = aa; v.ad = ad; v.br = br; v.bd = bd; v.rd = rd; v.cl = cl;
    v.en = en; v.addr = addr; v.data = data; v.oa = oa; v.ob = ob; v.cnt = cnt;
    return v;
  endfunction

  // Reference model: each requester owns a queue that never holds more than
  // one pending write; a request meeting a non-empty queue displaces it.
  typedef struct {
    logic [2:0]  addr;
    logic [95:0] data;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  bit   m_last_a;
  bit   m_ova, m_ovb;
  int   m_cnt;

  task automatic m_reset();
    qa.delete();
    qb.delete();
    m_last_a = 1'b0;
    m_ova = 1'b0;
    m_ovb = 1'b0;
    m_cnt = 0;
  endtask

  // 0 = nothing, 1 = A, 2 = B
  function automatic int m_pick(input logic rd);
    if (rd) return 0;
    if (qa.size() > 0 && qb.size() > 0) return m_last_a ? 2 : 1;
    if (qa.size() > 0) return 1;
    if (qb.size() > 0) return 2;
    return 0;
  endfunction

  task automatic m_expect(inout vec_t v);
    int p;
    p = m_pick(v.rd);
    v.en = 1'b0; v.addr = '0; v.data = '0;
    if (p == 1) begin
      v.en = 1'b1; v.addr = qa[0].addr; v.data = qa[0].data;
    end else if (p == 2) begin
      v.en = 1'b1; v.addr = qb[0].addr; v.data = qb[0].data;
    end
    v.oa = m_ova; v.ob = m_ovb; v.cnt = 8'(m_cnt);
  endtask

  task automatic m_step(input vec_t v);
    int   p;
    int   drops;
    ent_t e;
    p = m_pick(v.rd);
    if (p == 1) begin void'(qa.pop_front()); m_last_a = 1'b1; end
    if (p == 2) begin void'(qb.pop_front()); m_last_a = 1'b0; end
    drops = 0;
    if (v.ar) begin
      if (qa.size() > 0) begin void'(qa.pop_front()); m_ova = 1'b1; drops++; end
      e.addr = {1'b0, v.aa};
      e.data = {88'd0, v.ad};
      qa.push_back(e);
    end
    if (v.br) begin
      if (qb.size() > 0) begin void'(qb.pop_front()); m_ovb = 1'b1; drops++; end
      e.addr = 3'b100;
      e.data = v.bd;
      qb.push_back(e);
    end
    m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
    if (v.cl) begin m_ova = 1'b0; m_ovb = 1'b0; m_cnt = 0; end
  endtask

  task automatic check(input string tag, input vec_t v);
    n_vec++;
    if (wr_en !== v.en || wr_addr !== v.addr || wr_data !== v.data ||
        ovf_a !== v.oa || ovf_b !== v.ob || drop_cnt !== v.cnt) begin
      n_err++;
      $display("FAIL %s: got en=%0b addr=%0h data=%0h ova=%0b ovb=%0b cnt=%0d, want en=%0b addr=%0h data=%0h ova=%0b ovb=%0b cnt=%0d",
               tag, wr_en, wr_addr, wr_data, ovf_a, ovf_b, drop_cnt,
               v.en, v.addr, v.data, v.oa, v.ob, v.cnt);
    end
  endtask

  // One cycle: drive just after the edge, sample mid-cycle, advance model.
  task automatic run_vec(input vec_t v, input bit use_model, input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    a_req = v.ar; a_addr = v.aa; a_data = v.ad;
    b_req = v.br; b_data = v.bd; rd_en = v.rd; clr = v.cl;
    #3;
    e = v;
    if (use_model) m_expect(e);
    check(tag, e);
    m_step(v);
  endtask

  function automatic vec_t idle_in(input logic rd);
    return mk(0, 0, 0, 0, 0, rd, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 0; a_addr = 0; a_data = 0; b_req = 0; b_data = 0; rd_en = 0; clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    vec_t v;
    vec_t z;

    //      ar aa  ad     br bd              rd cl   en addr    data             oa ob cnt
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(1, 2, 8'h5A, 1, 96'hDEADBEEF, 0, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b010, 96'h5A,       0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b100, 96'hDEADBEEF, 0, 0, 0));
    tv.push_back(mk(1, 2, 8'h5A, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b010, 96'h5A,       0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(1, 1, 8'h33, 1, 96'h77,       0, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b100, 96'h77,       0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b001, 96'h33,       0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 96'h1234,     1, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,      1, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b100, 96'h1234,     0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 96'h1,        1, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 96'h2,        1, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        1, 0,   0, 3'b000, 96'h0,        0, 1, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b100, 96'h2,        0, 1, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 1, 1));
    tv.push_back(mk(1, 3, 8'hAA, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 1, 1));
    tv.push_back(mk(1, 0, 8'hBB, 0, 96'h0,        0, 0,   1, 3'b011, 96'hAA,       0, 1, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b000, 96'hBB,       0, 1, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 1, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 1,   0, 3'b000, 96'h0,        0, 1, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(1, 1, 8'h01, 0, 96'h0,        1, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(1, 1, 8'h02, 0, 96'h0,        1, 1,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b001, 96'h2,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(1, 2, 8'h03, 1, 96'h5,        1, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(1, 2, 8'h04, 1, 96'h6,        1, 0,   0, 3'b000, 96'h0,        0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        1, 0,   0, 3'b000, 96'h0,        1, 1, 2));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b100, 96'h6,        1, 1, 2));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b010, 96'h4,        1, 1, 2));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        1, 1, 2));
    tv.push_back(mk(0, 0, 8'h00, 1, 96'h9,        0, 0,   0, 3'b000, 96'h0,        1, 1, 2));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        1, 0,   0, 3'b000, 96'h0,        1, 1, 2));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   1, 3'b100, 96'h9,        1, 1, 2));
    tv.push_back(mk(0, 0, 8'h00, 0, 96'h0,        0, 0,   0, 3'b000, 96'h0,        1, 1, 2));

    do_reset();

    for (int i = 0; i < tv.size(); i++)
      run_vec(tv[i], 1'b0, $sformatf("table[%0d]", i));

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v = idle_in(0);
      v.ar = ($urandom_range(99, 0) < 30);
      v.aa = 2'($urandom_range(3, 0));
      v.ad = 8'($urandom);
      v.br = ($urandom_range(99, 0) < 30);
      v.bd = {$urandom, $urandom, $urandom};
      v.rd = ($urandom_range(99, 0) < 25);
      v.cl = ($urandom_range(99, 0) < 3);
      run_vec(v, 1'b1, "random");
    end

    // Long read stall with continuous B overwrites drives the counter to saturation.
    for (int i = 0; i < 300; i++) begin
      v = idle_in(1);
      v.br = 1'b1;
      v.bd = {$urandom, $urandom, $urandom};
      run_vec(v, 1'b1, "sat_stall");
    end
    #1;
    z = idle_in(0);
    z.cnt = 8'd255; z.ob = 1'b1; z.oa = wr_en; z.oa = ovf_a;
    n_vec++;
    if (drop_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL sat_cnt: got cnt=%0d, want cnt=255", drop_cnt);
    end

    // Reset arrives mid-stall with B still pending.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    a_req = 0; b_req = 0; rd_en = 0; clr = 0;
    #2;
    check("in_reset", idle_in(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 5; i++)
      run_vec(idle_in(0), 1'b1, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
